ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 16 +
 rtl/ram_arbiter_rr_arb2.sv | 27 ++
 rtl/ram_arbiter.sv | 101 ++++++++++
 tb/tb_ram_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter.
//   state_t : arbiter FSM state encoding
//   ADDR_W  : RAM word address width
//   DATA_W  : RAM data width
package ram_arbiter_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-input round-robin winner selection (combinational).
//   req0, req1  : pending requests
//   last_grant  : index of the most recently granted requester
//   grant_valid : at least one request is pending
//   grant_idx   : index of the winning requester
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  always_comb begin
    grant_valid = req0 | req1;
    // On contention the port that did not win last time goes next;
    // otherwise the sole requester wins.
    if (req0 && req1) begin
      grant_idx = ~last_grant;
    end else begin
      grant_idx = req1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one external single-port RAM.
// Each transaction takes IDLE -> ACCESS -> DONE (3 cycles).
//   clk, clr            : clock, synchronous active-high reset
//   req*/we*/addr*/wdata*: per-port request, write enable, address, data
//   ack*                : one-cycle completion pulse (in DONE)
//   rdata*              : per-port read data, held until next ack
//   ram_rw/ram_addr/ram_data_in : RAM controls, driven in ACCESS
//   ram_data_out        : combinational RAM read data
//   busy                : FSM not in IDLE
//   last_grant          : most recently granted requester
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned N_WORDS = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy,
  output logic              last_grant
);

  // The address width is fixed, so the word count must fill it exactly.
  if (N_WORDS != (1 << ADDR_W)) begin : g_bad_size
    $error("ram_arbiter: N_WORDS must equal 2**ADDR_W");
  end

  state_t state, state_nxt;
  logic   grant_valid, grant_idx;
  logic   lat_we, lat_port;

  rr_arb2 u_arb (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ram_addr/ram_data_in double as the latched address and write data:
  // loaded on the grant edge so they are valid throughout ACCESS and
  // simply hold afterwards.
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      lat_we      <= 1'b0;
      lat_port    <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      ram_addr    <= '0;
      ram_data_in <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_valid) begin
        last_grant  <= grant_idx;
        lat_port    <= grant_idx;
        lat_we      <= grant_idx ? we1 : we0;
        ram_addr    <= grant_idx ? addr1 : addr0;
        ram_data_in <= grant_idx ? wdata1 : wdata0;
      end
      if (state == ACCESS && !lat_we) begin
        if (lat_port) rdata1 <= ram_data_out;
        else          rdata0 <= ram_data_out;
      end
    end
  end

  always_comb begin
    ram_rw = (state == ACCESS) && lat_we;
    ack0   = (state == DONE) && !lat_port;
    ack1   = (state == DONE) && lat_port;
    busy   = (state != IDLE);
  end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  typedef struct {
    bit         we;
    logic [2:0] addr;
    logic [7:0] data;
  } op_t;

  typedef struct {
    bit          port;
    int unsigned cyc;
    logic [7:0]  rdata;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr, req0, req1, we0, we1;
  logic [2:0] addr0, addr1, ram_addr;
  logic [7:0] wdata0, wdata1, rdata0, rdata1, ram_data_in, ram_data_out;
  logic       ack0, ack1, ram_rw, busy, last_grant;

  logic [7:0] ram [8];
  logic [7:0] mem [8];
  logic [7:0] last_rd [2];
  bit          model_last;
  int unsigned exp_writes = 0;
  int unsigned rw_cycles  = 0;
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;

  op_t  q0[$], q1[$];
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arbiter #(.N_WORDS(8)) dut (
    .clk(clk), .clr(clr), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .busy(busy), .last_grant(last_grant)
  );

  // External 8x8 RAM
  always @(posedge clk) if (ram_rw) ram[ram_addr] <= ram_data_in;
  assign ram_data_out = ram[ram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever an ack appears.
  always @(negedge clk) begin
    if (clr !== 1'b1) begin
      if (ram_rw === 1'b1) rw_cycles++;
      if (ack0 === 1'b1 && ack1 === 1'b1) chk("ack_exclusive", 32'({ack0, ack1}), 32'b10);
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_ack", 32'({ack0, ack1}), 32'b00);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("ack_port", 32'(ack1), 32'(e.port));
          chk("ack_cycle", cyc, e.cyc);
          chk("rdata", e.port ? 32'(rdata1) : 32'(rdata0), 32'(e.rdata));
          chk("last_grant", 32'(last_grant), 32'(e.port));
          chk("ram_rw_in_done", 32'(ram_rw), 32'b0);
        end
      end
    end
  end

  task automatic present0();
    if (q0.size() > 0) begin
      req0 = 1'b1; we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].data;
    end else req0 = 1'b0;
  endtask

  task automatic present1();
    if (q1.size() > 0) begin
      req1 = 1'b1; we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].data;
    end else req1 = 1'b0;
  endtask

  // Issues the queued ops of both ports with req held continuously;
  // the reference model decides the grant order and expected results.
  task automatic run_batch();
    op_t a[$], b[$], op;
    int unsigned c0, k, budget;
    bit w;
    @(posedge clk); #1;
    c0 = cyc;
    a = q0; b = q1; k = 0;
    while (a.size() > 0 || b.size() > 0) begin
      if (a.size() > 0 && b.size() > 0) w = ~model_last;
      else w = (a.size() == 0);
      op = w ? b.pop_front() : a.pop_front();
      if (op.we) begin
        mem[op.addr] = op.data;
        exp_writes++;
      end else begin
        last_rd[w] = mem[op.addr];
      end
      sbq.push_back('{port: w, cyc: c0 + 2 + 3 * k, rdata: last_rd[w]});
      model_last = w;
      k++;
    end
    present0(); present1();
    budget = 3 * (q0.size() + q1.size()) + 8;
    while ((q0.size() > 0 || q1.size() > 0) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (ack0 === 1'b1 && q0.size() > 0) begin void'(q0.pop_front()); present0(); end
      if (ack1 === 1'b1 && q1.size() > 0) begin void'(q1.pop_front()); present1(); end
    end
    chk("batch_complete", q0.size() + q1.size(), 0);
    q0.delete(); q1.delete();
    req0 = 1'b0; req1 = 1'b0;
  endtask

  function automatic op_t mk(input bit we, input logic [2:0] addr, input logic [7:0] data);
    op_t o;
    o.we = we; o.addr = addr; o.data = data;
    return o;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      ram[i] = 8'(i * 19 + 7);
      mem[i] = 8'(i * 19 + 7);
    end
    clr = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    last_rd[0] = '0; last_rd[1] = '0; model_last = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'({ack0, ack1}), 0);
    chk("rst_rdata0", 32'(rdata0), 0);
    chk("rst_rdata1", 32'(rdata1), 0);
    chk("rst_ram_rw", 32'(ram_rw), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_data_in", 32'(ram_data_in), 0);
    chk("rst_last_grant", 32'(last_grant), 1);
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    // Simultaneous: port 0 reads addr 7, port 1 writes 3C; then read back
    q0.push_back(mk(0, 3'd7, 8'h00));
    q1.push_back(mk(1, 3'd7, 8'h3C));
    run_batch();
    q0.push_back(mk(0, 3'd7, 8'h00));
    run_batch();

    // Port 0 write then read of addr 5
    q0.push_back(mk(1, 3'd5, 8'hA5));
    q0.push_back(mk(0, 3'd5, 8'h00));
    run_batch();

    // Both continuously requesting reads
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(0, 3'(i), 8'h00));
      q1.push_back(mk(0, 3'(i + 4), 8'h00));
    end
    run_batch();

    // Fill all addresses alternating ports, then read back
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) q0.push_back(mk(1, 3'(i), 8'((i + 1) * 8'h11)));
      else            q1.push_back(mk(1, 3'(i), 8'((i + 1) * 8'h11)));
    end
    run_batch();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) q1.push_back(mk(0, 3'(i), 8'h00));
      else            q0.push_back(mk(0, 3'(i), 8'h00));
    end
    run_batch();

    // clr during ACCESS of a port 1 read of addr 2
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd2;
    @(posedge clk); #1;
    chk("abort_in_access", 32'(busy), 1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; req1 = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0; model_last = 1'b1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ack1", 32'(ack1), 0);
    chk("abort_rdata1", 32'(rdata1), 0);
    chk("abort_ram_rw", 32'(ram_rw), 0);
    repeat (4) @(negedge clk);

    // Randomized batches
    for (int n = 0; n < 25; n++) begin
      int unsigned n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 + n1 == 0) n0 = 1;
      for (int i = 0; i < int'(n0); i++)
        q0.push_back(mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom)));
      for (int i = 0; i < int'(n1); i++)
        q1.push_back(mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom)));
      run_batch();
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    chk("write_cycles", rw_cycles, exp_writes);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
